disp_sched: RTL
===============

# disp_sched

Scheduler that shares the 4-digit seven-segment display between four counter channels. It captures each channel's 16-bit value on that channel's update strobe and chooses which channel is shown. Selection is by timed auto-rotation, by manual step, or by urgent preemption. It drives the display block's `dat[15:0]` and `PTR[1:0]` inputs, with the decimal-point position identifying the source channel, and consumes that block's `ce1ms` tick.

## Interface
Parameters:
- `DWELL_MS`, default 1000: ms each channel is shown in auto mode; legal range ≥1.
- `HOLD_MS`, default 3000: ms an urgent channel holds the display; legal range ≥1.

Ports:
- `clk`  in  1  system clock, the single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ce1ms`  in  1  one-cycle tick every 1 ms, from the display block.
- `mode`  in  1  0 = auto-rotate, 1 = manual.
- `btn_next`  in  1  one-cycle pulse, debounced upstream; advances selection.
- `upd`  in  4  per-channel capture strobe.
- `urg`  in  4  per-channel urgent request, sampled as a level each cycle.
- `val0`…`val3`  in  16 each  channel values, valid only when the matching `upd` bit is high.
- `dat`  out  16  displayed value, registered.
- `PTR`  out  2  displayed channel index, registered; equals `sel`.
- `ack`  out  4  one-cycle capture acknowledge per channel.
- `preempt`  out  1  high while in state PRE.

## Operation
- **Capture.** `upd[i]` high at edge t writes `cap[i] <= val_i`, and `ack[i]` is high for the cycle after edge t. All four channels capture independently and simultaneously.
- **Output register.** `dat <= cap[sel_next]`. If `upd[sel_next]` is high in the same cycle, `val` is bypassed into `dat` instead.
- **States (`disp_pkg::state_t`):**
  - ROT: dwell timer counts `ce1ms`. When the count reaches `DWELL_MS`, `sel` advances and the timer clears.
  - MAN: `sel` advances only on `btn_next`.
  - PRE: an urgent channel is shown.
- **Advance rule.** `sel <= sel + 1`, wrapping from 3 to 0.
- **ROT ↔ MAN.** The state follows `mode` on the next edge, and the dwell timer clears on any mode change.
- **`btn_next` in ROT.** The pulse advances `sel` and clears the dwell timer.
- **Entering PRE.** Any `urg` bit high in ROT or MAN saves `sel` to `sel_save`, sets `sel` to the lowest set `urg` index, clears the hold timer, and enters PRE.
- **Inside PRE:**
  - `urg[j]` with j < `sel`: switch to j and clear the hold timer.
  - `urg[sel]` still high: hold timer held at 0, so the hold is re-armed.
  - `urg[j]` with j > `sel`: ignored.
  - `btn_next`: ignored.
- **Leaving PRE.** When the hold timer reaches `HOLD_MS` and `urg[sel]` is low:
  - `sel <= sel_save`;
  - next state is ROT or MAN according to the current `mode`;
  - dwell timer cleared.
- **Priority within one cycle.** urg entry/switch > `btn_next` > dwell expiry > mode change. When urg wins, the other events in that cycle are dropped.
- **Reset values.** `cap[*]=0`, `dat=0`, `PTR=0`, `sel_save=0`, `ack=0`, `preempt=0`, both timers 0, state ROT. The first post-reset edge with `mode=1` enters MAN.
- **Widths.** Timers are `$clog2(max(DWELL_MS,HOLD_MS)+1)` bits and saturate, so they never wrap. `sel` is 2 bits and wraps modulo 4.

## Timing
- Latency is one edge for every event:
  - `upd` → `cap` / `dat` / `ack`;
  - `btn_next` / `urg` / dwell expiry → `sel` / `PTR` / `dat` / `preempt`.
- Auto dwell is exactly `DWELL_MS` `ce1ms` ticks after a timer clear. The first tick is counted at the first `ce1ms` following the clear.
- PRE lasts `HOLD_MS` ticks after `urg[sel]` falls, with ±1 ms tick phase.
- Asynchronous `rst_n` assertion mid-PRE or mid-dwell returns all outputs to their reset values immediately. Operation restarts on the first edge after deassertion.
- No combinational path from any input to any output.

## Structure
- **`disp_pkg`** holds:
  - `state_t` enum {ROT, MAN, PRE};
  - `N_CH=4`;
  - `IDX_W=2`;
  - the lowest-set-bit priority function.
- **`tick_timer`** (parameter `TERM`; ports `clk`, `rst_n`, `ce`, `clr`, `done`): saturating `ce1ms` counter, instantiated twice (dwell with `TERM=DWELL_MS`, hold with `TERM=HOLD_MS`).
- **`disp_sched`** contains:
  - the capture registers;
  - the FSM;
  - the `sel` / `sel_save` registers;
  - the `dat` output mux/register.

## Test plan
- Auto rotation (`DWELL_MS`=3, `mode`=0, channels loaded with 0x1111/0x2222/0x3333/0x4444) → `PTR` steps 0,1,2,3,0 every 3 ticks, with `dat` matching the channel.
- Manual mode (`mode`=1):
  - three `btn_next` pulses → `PTR`=3;
  - a fourth pulse → `PTR`=0;
  - no change on `ce1ms` alone.
- Capture bypass: `upd[2]` with `val2`=0xBEEF while `sel`=2 → `dat`=0xBEEF and `ack[2]` high on the next edge; `cap[2]`=0xBEEF.
- Urgent preemption:
  - in ROT with `sel`=1, `urg`=4'b1100 for one cycle → `PTR`=2 and `preempt`=1;
  - then `urg[0]` pulse → `PTR`=0;
  - after `HOLD_MS` ticks → `PTR`=1, `preempt`=0.
- Simultaneous events: `btn_next`, dwell expiry and `urg[3]` in the same cycle → `PTR`=3; the btn and dwell advances are lost.
- Reset mid-PRE: `rst_n` low asynchronously between edges → `dat`=0, `PTR`=0, `preempt`=0, `ack`=0 immediately; after release, state is ROT.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and helpers for the seven-segment display scheduler.
package disp_pkg;

    typedef enum logic [1:0] {ROT, MAN, PRE} state_t;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned IDX_W = 2;

    // Index of the lowest set request bit; 0 when none is set (callers gate on |v).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_CH-1:0] v);
        lowest_set = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Saturating counter of ce ticks; done is high once TERM ticks have been seen since clr.
module tick_timer #(
    parameter int unsigned TERM = 1,
    parameter int unsigned W    = $clog2(TERM + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic clr,
    output logic done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ce && (cnt != W'(TERM))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == W'(TERM));

endmodule

// File: rtl/disp_sched.sv
// Chooses which of four captured channel values drives the display: timed rotation,
// manual stepping, or urgent preemption with a hold time.
module disp_sched
    import disp_pkg::*;
#(
    parameter int unsigned DWELL_MS = 1000,
    parameter int unsigned HOLD_MS  = 3000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce1ms,
    input  logic             mode,
    input  logic             btn_next,
    input  logic [N_CH-1:0]  upd,
    input  logic [N_CH-1:0]  urg,
    input  logic [15:0]      val0,
    input  logic [15:0]      val1,
    input  logic [15:0]      val2,
    input  logic [15:0]      val3,
    output logic [15:0]      dat,
    output logic [IDX_W-1:0] PTR,
    output logic [N_CH-1:0]  ack,
    output logic             preempt
);

    localparam int unsigned TMR_MAX = (DWELL_MS > HOLD_MS) ? DWELL_MS : HOLD_MS;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    logic [15:0]      val [N_CH];
    logic [15:0]      cap [N_CH];
    state_t           state, state_next;
    logic [IDX_W-1:0] sel, sel_next, sel_save, save_next, lo;
    logic             urg_any, urg_lower, dwell_done, hold_done, dwell_clr, hold_clr;

    assign val[0] = val0;
    assign val[1] = val1;
    assign val[2] = val2;
    assign val[3] = val3;

    assign lo        = lowest_set(urg);
    assign urg_any   = |urg;
    assign urg_lower = urg_any && (lo < sel);

    always_comb begin
        state_next = state;
        sel_next   = sel;
        save_next  = sel_save;
        unique case (state)
            ROT, MAN: begin
                if (urg_any) begin
                    state_next = PRE;
                    save_next  = sel;
                    sel_next   = lo;
                end else if (btn_next) begin
                    sel_next = sel + 1'b1;
                end else if ((state == ROT) && dwell_done) begin
                    sel_next = sel + 1'b1;
                end else begin
                    state_next = mode ? MAN : ROT;
                end
            end
            PRE: begin
                if (urg_lower) begin
                    sel_next = lo;
                end else if (hold_done && !urg[sel]) begin
                    sel_next   = sel_save;
                    state_next = mode ? MAN : ROT;
                end
            end
            default: state_next = ROT;
        endcase
    end

    // Dwell only runs while rotating undisturbed; hold is pinned at 0 while urg[sel] is high.
    assign dwell_clr = (state != ROT) || mode || urg_any || btn_next || dwell_done;
    assign hold_clr  = (state != PRE) || urg[sel] || urg_lower;

    tick_timer #(.TERM(DWELL_MS), .W(TMR_W)) u_dwell (
        .clk  (clk),
        .rst_n(rst_n),
        .ce   (ce1ms),
        .clr  (dwell_clr),
        .done (dwell_done)
    );

    tick_timer #(.TERM(HOLD_MS), .W(TMR_W)) u_hold (
        .clk  (clk),
        .rst_n(rst_n),
        .ce   (ce1ms),
        .clr  (hold_clr),
        .done (hold_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ROT;
            sel      <= '0;
            sel_save <= '0;
            dat      <= '0;
            ack      <= '0;
            preempt  <= 1'b0;
            for (int i = 0; i < N_CH; i++) cap[i] <= '0;
        end else begin
            state    <= state_next;
            sel      <= sel_next;
            sel_save <= save_next;
            ack      <= upd;
            preempt  <= (state_next == PRE);
            dat      <= upd[sel_next] ? val[sel_next] : cap[sel_next];
            for (int i = 0; i < N_CH; i++) begin
                if (upd[i]) cap[i] <= val[i];
            end
        end
    end

    assign PTR = sel;

endmodule
